keypad_pin_collector: RTL and testbench
=======================================

Name: keypad_pin_collector

Overview:
Upstream stage of the parking access controller. It collects BCD digits from the gate keypad decoder into a 4-digit PIN. On ENTER it delivers the PIN as a 16-bit word with a one-cycle valid strobe. The downstream access FSM compares that word against the stored code.

Parameters:
TIMEOUT_CYCLES, 16'd50000, clock cycles allowed between keypad events before a partial entry is discarded (minimum 2)
CNT_W, 16, width of the inactivity counter (must hold TIMEOUT_CYCLES-1)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low; clears all state immediately when 0
habilitar  input  1  collection enable, driven by sensor_llegada_vehiculo
tecla_valida  input  1  one-cycle strobe: digito is a new key press
digito  input  4  BCD digit value, 0..9 legal
tecla_enter  input  1  one-cycle strobe: ENTER pressed
tecla_borrar  input  1  one-cycle strobe: CLEAR pressed
clave_ingresada  output  16  last delivered PIN, first digit in [15:12], fourth digit in [3:0]
clave_valida  output  1  one-cycle strobe: clave_ingresada has just been updated
cuenta_digitos  output  3  digits currently buffered, 0..4
digito_invalido  output  1  one-cycle pulse: rejected digit (>9, or a 5th digit)
entrada_incompleta  output  1  one-cycle pulse: ENTER pressed with fewer than 4 digits
tiempo_agotado  output  1  one-cycle pulse: partial entry discarded on timeout

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state ESPERA, buffer 16'h0000, cuenta_digitos 0, inactivity counter 0.
  - clave_ingresada 16'h0000.
  - All strobes and pulses 0.
- Internal buffer:
  - buf[15:0]; each accepted digit does buf <= {buf[11:0], digito}, cuenta_digitos += 1.
- Per-cycle event priority:
  - !habilitar > tecla_borrar > tecla_enter > tecla_valida > timeout.
  - Lower-priority events in the same cycle are ignored, with no error pulses.
- States:
  - ESPERA: buffer empty. A legal digit is loaded into the buffer, counter cleared, next state CAPTURA. ENTER pulses entrada_incompleta and the state stays ESPERA. CLEAR has no effect. The counter does not run.
  - CAPTURA (1..3 digits):
    - A legal digit is shifted in and the counter cleared. On the 4th digit the next state is LISTA.
    - ENTER pulses entrada_incompleta, clears the buffer, next state ESPERA.
    - CLEAR clears the buffer, next state ESPERA.
  - LISTA (4 digits): any further digit pulses digito_invalido and the buffer is unchanged. ENTER moves to ENTREGA. CLEAR clears the buffer and returns to ESPERA.
  - ENTREGA (one cycle):
    - clave_ingresada <= buf and clave_valida=1 for exactly this cycle.
    - Buffer and cuenta_digitos cleared, next state ESPERA.
    - Key inputs are ignored this cycle. habilitar dropping here does not cancel delivery.
- Latency: clave_valida is high in the cycle after the cycle in which tecla_enter is sampled in LISTA.
- Illegal digit (digito>9) in any collecting state: pulse digito_invalido. Buffer, count and counter are unchanged.
- Inactivity counter:
  - Runs only in CAPTURA and LISTA, incrementing every cycle without an accepted key event.
  - Cleared by an accepted digit or by leaving the state. Rejected digits do not clear it.
  - On reaching TIMEOUT_CYCLES-1: pulse tiempo_agotado, clear the buffer, next state ESPERA.
  - No wrap-around is possible.
- habilitar=0 in ESPERA, CAPTURA or LISTA:
  - Buffer silently cleared, state forced to ESPERA, all key inputs ignored.
  - No error pulse is raised.
- clave_ingresada holds its value until the next delivery; it is never cleared except by reset.
- Pulse exclusivity: at most one of digito_invalido, entrada_incompleta, tiempo_agotado is high in any cycle.
- Unused state encodings recover to ESPERA with the buffer cleared.

Test Plan:
- Delivery: habilitar=1, digits 2,4,6,8 then ENTER → clave_valida high for 1 cycle, the cycle after ENTER; clave_ingresada=16'h2468; cuenta_digitos returns to 0.
- Short entry: digits 1,3 then ENTER → entrada_incompleta pulse; no clave_valida; clave_ingresada keeps its prior value; state ESPERA.
- Rejected digits: digits 1,2,3,4, then digit 5 (5th digit), then digit 4'hA, then ENTER → two digito_invalido pulses; clave_ingresada=16'h1234.
- Clear priority: digits 9,9, then CLEAR asserted in the same cycle as digit 7 → cuenta_digitos=0 and digit 7 discarded; then digits 0,0,0,1 and ENTER → 16'h0001.
- Timeout: TIMEOUT_CYCLES=8; digit 5, then idle 7 cycles → tiempo_agotado pulse on the 7th idle cycle and buffer cleared. Variant: idle 6 cycles then a digit → no timeout.
- Abort and reset:
  - habilitar dropped after 3 digits → buffer cleared, no pulses.
  - reset asserted asynchronously mid-entry between clock edges → outputs zero immediately, before the next clock edge.
  - ENTER one cycle before habilitar falls → delivery still completes.

Source files
------------

// File: rtl/keypad_pin_collector.sv
// Keypad PIN collector: buffers four BCD digits and delivers them on ENTER
// as a 16-bit word with a one-cycle valid strobe.
module keypad_pin_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 16'd50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilitar,
    input  logic        tecla_valida,
    input  logic [3:0]  digito,
    input  logic        tecla_enter,
    input  logic        tecla_borrar,
    output logic [15:0] clave_ingresada,
    output logic        clave_valida,
    output logic [2:0]  cuenta_digitos,
    output logic        digito_invalido,
    output logic        entrada_incompleta,
    output logic        tiempo_agotado
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CAPTURA = 2'd1,
        LISTA   = 2'd2,
        ENTREGA = 2'd3
    } state_e;

    // Timer fires on the idle cycle that would bring it to TIMEOUT_CYCLES-1
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);

    state_e             state_q;
    logic [15:0]        buffer_q;
    logic [2:0]         count_q;
    logic [CNT_W-1:0]   tmr_q;
    logic [15:0]        clave_q;
    logic               valida_q;
    logic               inv_q;
    logic               inc_q;
    logic               to_q;

    logic legal;
    assign legal = (digito <= 4'd9);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ESPERA;
            buffer_q <= 16'h0000;
            count_q  <= 3'd0;
            tmr_q    <= '0;
            clave_q  <= 16'h0000;
            valida_q <= 1'b0;
            inv_q    <= 1'b0;
            inc_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            valida_q <= 1'b0;
            inv_q    <= 1'b0;
            inc_q    <= 1'b0;
            to_q     <= 1'b0;
            unique case (state_q)
                ESPERA: begin
                    tmr_q <= '0;
                    if (!habilitar || tecla_borrar) begin
                        buffer_q <= 16'h0000;
                        count_q  <= 3'd0;
                    end else if (tecla_enter) begin
                        inc_q <= 1'b1;
                    end else if (tecla_valida) begin
                        if (!legal) begin
                            inv_q <= 1'b1;
                        end else begin
                            buffer_q <= {12'h000, digito};
                            count_q  <= 3'd1;
                            state_q  <= CAPTURA;
                        end
                    end
                end
                CAPTURA, LISTA: begin
                    if (!habilitar || tecla_borrar) begin
                        buffer_q <= 16'h0000;
                        count_q  <= 3'd0;
                        tmr_q    <= '0;
                        state_q  <= ESPERA;
                    end else if (tecla_enter) begin
                        if (state_q == LISTA) begin
                            clave_q  <= buffer_q;
                            valida_q <= 1'b1;
                            state_q  <= ENTREGA;
                        end else begin
                            inc_q   <= 1'b1;
                            state_q <= ESPERA;
                        end
                        buffer_q <= 16'h0000;
                        count_q  <= 3'd0;
                        tmr_q    <= '0;
                    end else if (tecla_valida) begin
                        if (!legal || state_q == LISTA) begin
                            inv_q <= 1'b1;
                        end else begin
                            buffer_q <= {buffer_q[11:0], digito};
                            count_q  <= count_q + 3'd1;
                            tmr_q    <= '0;
                            if (count_q == 3'd3) state_q <= LISTA;
                        end
                    end else if (tmr_q >= LIMIT) begin
                        to_q     <= 1'b1;
                        buffer_q <= 16'h0000;
                        count_q  <= 3'd0;
                        tmr_q    <= '0;
                        state_q  <= ESPERA;
                    end else begin
                        tmr_q <= tmr_q + CNT_W'(1);
                    end
                end
                ENTREGA: begin
                    buffer_q <= 16'h0000;
                    count_q  <= 3'd0;
                    tmr_q    <= '0;
                    state_q  <= ESPERA;
                end
                default: begin
                    buffer_q <= 16'h0000;
                    count_q  <= 3'd0;
                    tmr_q    <= '0;
                    state_q  <= ESPERA;
                end
            endcase
        end
    end

    assign clave_ingresada    = clave_q;
    assign clave_valida       = valida_q;
    assign cuenta_digitos     = count_q;
    assign digito_invalido    = inv_q;
    assign entrada_incompleta = inc_q;
    assign tiempo_agotado     = to_q;

endmodule

// File: tb/tb_keypad_pin_collector.sv
// Randomized scoreboard bench for keypad_pin_collector against a
// digit-queue reference model.
module tb_keypad_pin_collector;

    localparam int T = 8;

    logic        clock;
    logic        reset;
    logic        habilitar;
    logic        tecla_valida;
    logic [3:0]  digito;
    logic        tecla_enter;
    logic        tecla_borrar;
    logic [15:0] clave_ingresada;
    logic        clave_valida;
    logic [2:0]  cuenta_digitos;
    logic        digito_invalido;
    logic        entrada_incompleta;
    logic        tiempo_agotado;

    keypad_pin_collector #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .habilitar(habilitar),
        .tecla_valida(tecla_valida),
        .digito(digito),
        .tecla_enter(tecla_enter),
        .tecla_borrar(tecla_borrar),
        .clave_ingresada(clave_ingresada),
        .clave_valida(clave_valida),
        .cuenta_digitos(cuenta_digitos),
        .digito_invalido(digito_invalido),
        .entrada_incompleta(entrada_incompleta),
        .tiempo_agotado(tiempo_agotado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected output events: 0 delivery, 1 bad digit, 2 short entry, 3 timeout
    typedef struct {
        int          kind;
        logic [15:0] val;
        int          cyc;
    } ev_t;
    ev_t exp_q[$];

    int          mq[$];
    bit          m_deliv = 0;
    int          m_idle  = 0;
    logic [15:0] m_last  = 16'h0000;

    function automatic void push_ev(int k, logic [15:0] v, int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_deliv = 0;
        m_idle  = 0;
        m_last  = 16'h0000;
    endfunction

    function automatic void model(bit h, bit v, logic [3:0] d,
                                  bit e, bit c, int at);
        int pin;
        if (m_deliv) begin
            m_deliv = 0;
            return;
        end
        if (!h || c) begin
            mq.delete();
            m_idle = 0;
            return;
        end
        if (e) begin
            if (mq.size() == 4) begin
                pin = 0;
                foreach (mq[i]) pin = pin * 16 + mq[i];
                m_last  = 16'(pin);
                m_deliv = 1;
                push_ev(0, 16'(pin), at);
            end else begin
                push_ev(2, 16'h0, at);
            end
            mq.delete();
            m_idle = 0;
            return;
        end
        if (v) begin
            if (d > 9 || mq.size() == 4) push_ev(1, 16'h0, at);
            else begin
                mq.push_back(int'(d));
                m_idle = 0;
            end
            return;
        end
        if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == T - 1) begin
                push_ev(3, 16'h0, at);
                mq.delete();
                m_idle = 0;
            end
        end
    endfunction

    // Called at posedge+2; leaves at the following posedge+2
    task automatic step(bit h, bit v, logic [3:0] d, bit e, bit c);
        habilitar    = h;
        tecla_valida = v;
        digito       = d;
        tecla_enter  = e;
        tecla_borrar = c;
        model(h, v, d, e, c, cyc + 1);
        @(posedge clock);
        #1;
        chk("cuenta_digitos", int'(cuenta_digitos), mq.size());
        chk("clave_ingresada", int'(clave_ingresada), int'(m_last));
        #1;
    endtask

    task automatic key(logic [3:0] d);
        step(1, 1, d, 0, 0);
    endtask

    task automatic enter();
        step(1, 0, 4'd0, 1, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'd0, 0, 0);
    endtask

    function automatic void match(int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d", k, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc ||
            (k == 0 && e.val != clave_ingresada)) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d val %h expected kind %0d cyc %0d val %h",
                     k, cyc, clave_ingresada, e.kind, e.cyc, e.val);
        end
    endfunction

    initial begin
        ev_t e;
        int  p;
        bit  seen;
        forever begin
            @(negedge clock);
            p = int'(digito_invalido) + int'(entrada_incompleta)
              + int'(tiempo_agotado);
            chk("pulse_exclusive", p > 1 ? 1 : 0, 0);
            seen = 0;
            if (clave_valida)       begin match(0); seen = 1; end
            if (digito_invalido)    begin match(1); seen = 1; end
            if (entrada_incompleta) begin match(2); seen = 1; end
            if (tiempo_agotado)     begin match(3); seen = 1; end
            if (!seen && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: got none expected kind %0d at cycle %0d",
                         e.kind, e.cyc);
            end
        end
    end

    initial begin
        int pv, pe, pc;
        reset        = 1'b0;
        habilitar    = 1'b0;
        tecla_valida = 1'b0;
        digito       = 4'd0;
        tecla_enter  = 1'b0;
        tecla_borrar = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_clave", int'(clave_ingresada), 0);
        chk("rst_cuenta", int'(cuenta_digitos), 0);
        chk("rst_strobes", int'({clave_valida, digito_invalido,
                                 entrada_incompleta, tiempo_agotado}), 0);
        #1;
        reset = 1'b1;

        key(2); key(4); key(6); key(8); enter(); idle(1);
        chk("deliver_2468", int'(clave_ingresada), 16'h2468);

        key(1); key(3); enter(); idle(1);
        chk("short_keeps", int'(clave_ingresada), 16'h2468);

        key(1); key(2); key(3); key(4); key(5); key(4'hA); enter(); idle(1);
        chk("deliver_1234", int'(clave_ingresada), 16'h1234);

        key(9); key(9); step(1, 1, 4'd7, 0, 1);
        key(0); key(0); key(0); key(1); enter(); idle(1);
        chk("deliver_0001", int'(clave_ingresada), 16'h0001);

        key(5); idle(7);
        key(5); idle(6); key(3); idle(1);
        step(1, 0, 4'd0, 0, 1);

        key(1); key(2); key(3); step(0, 0, 4'd0, 0, 0); idle(1);

        key(7); key(7); key(7); key(7); enter();
        step(0, 0, 4'd0, 0, 0); idle(1);
        chk("deliver_7777", int'(clave_ingresada), 16'h7777);

        key(6); key(5);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_cuenta", int'(cuenta_digitos), 0);
        chk("async_rst_clave", int'(clave_ingresada), 0);
        chk("async_rst_valida", int'(clave_valida), 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit busy;
            busy = ((i / 150) % 2) == 0;
            pv = busy ? 45 : 6;
            pe = busy ? 10 : 2;
            pc = busy ? 4 : 1;
            step($urandom_range(0, 99) < 97,
                 $urandom_range(0, 99) < pv,
                 4'($urandom_range(0, 11)),
                 $urandom_range(0, 99) < pe,
                 $urandom_range(0, 99) < pc);
        end
        idle(3);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
